// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the tiny5 memory-port arbiter.
//   mem_access_size_t : bus access size encoding (value 3 is illegal)
//   arb_state_t       : arbiter FSM states
//   mem_port_t        : which requester owns the in-flight transaction
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2,
    ARB_ERR_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    MEM_PORT_I = 1'b0,
    MEM_PORT_D = 1'b1
  } mem_port_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported tiny5 memory bus between instruction fetch (I) and
// load/store (D). Arbitrates in IDLE, registers the winning request, holds it
// on the bus until accepted, waits for the response and routes it back to the
// owner. Misaligned requests are answered locally with an error pulse.
//
// Ports:
//   clk_i, reset_n_i            clock, async active-low reset
//   i_req_* / i_addr_i          fetch request (always WORD)
//   i_resp_* / i_rdata_o        fetch response pulse, error, data
//   d_req_* / d_addr_i ...      load/store request
//   d_resp_* / d_rdata_o        load/store response pulse, error, data
//   mem_req_* / mem_*_o         bus request (held until mem_req_ready_i)
//   mem_resp_valid_i/rdata_i    bus response
//   busy_o                      FSM not idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              i_req_valid_i,
  output logic              i_req_ready_o,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_resp_valid_o,
  output logic              i_resp_err_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_wr_i,
  input  logic [1:0]        d_size_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_resp_valid_o,
  output logic              d_resp_err_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_size_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  // Value 3 is not a legal size, so it is rejected like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return lsb[0];
      MEM_SIZE_WORD: return lsb != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  arb_state_t          r_state;
  mem_port_t           r_owner;
  logic [StreakW-1:0]  r_streak;
  logic                r_mem_req_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [1:0]          r_size;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_i_resp_valid;
  logic                r_i_resp_err;
  logic [DATA_W-1:0]   r_i_rdata;
  logic                r_d_resp_valid;
  logic                r_d_resp_err;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_idle;
  logic                w_grant_i;
  logic                w_grant_d;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr;
  logic [1:0]          w_size;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_misaligned;

  // Grant is gated by reset so the ready outputs also read 0 while in reset.
  always_comb begin
    w_idle    = reset_n_i && (r_state == ARB_IDLE);
    // D normally wins a tie; I is forced through once D has won StreakMax in a row.
    w_grant_d = w_idle && d_req_valid_i && !(i_req_valid_i && (r_streak == StreakMax));
    w_grant_i = w_idle && i_req_valid_i && !w_grant_d;
    w_addr    = w_grant_d ? d_addr_i : i_addr_i;
    w_wr      = w_grant_d && d_wr_i;
    w_size    = w_grant_d ? d_size_i : MEM_SIZE_WORD;
    w_wdata   = w_grant_d ? d_wdata_i : '0;
    w_misaligned = is_misaligned(w_size, w_addr[1:0]);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state         <= ARB_IDLE;
      r_owner         <= MEM_PORT_I;
      r_streak        <= '0;
      r_mem_req_valid <= 1'b0;
      r_addr          <= '0;
      r_wr            <= 1'b0;
      r_size          <= '0;
      r_wdata         <= '0;
      r_i_resp_valid  <= 1'b0;
      r_i_resp_err    <= 1'b0;
      r_i_rdata       <= '0;
      r_d_resp_valid  <= 1'b0;
      r_d_resp_err    <= 1'b0;
      r_d_rdata       <= '0;
    end else begin
      // Response valids are single-cycle pulses; err/rdata hold between pulses.
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_grant_i || w_grant_d) begin
            r_owner <= w_grant_d ? MEM_PORT_D : MEM_PORT_I;
            r_addr  <= w_addr;
            r_wr    <= w_wr;
            r_size  <= w_size;
            r_wdata <= w_wdata;
            if (w_grant_d) begin
              r_streak <= (r_streak == StreakMax) ? r_streak : r_streak + 1'b1;
            end else begin
              r_streak <= '0;
            end
            if (w_misaligned) begin
              r_state <= ARB_ERR_RESP;
              if (w_grant_d) begin
                r_d_resp_valid <= 1'b1;
                r_d_resp_err   <= 1'b1;
                r_d_rdata      <= '0;
              end else begin
                r_i_resp_valid <= 1'b1;
                r_i_resp_err   <= 1'b1;
                r_i_rdata      <= '0;
              end
            end else begin
              r_state         <= ARB_ISSUE;
              r_mem_req_valid <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_req_ready_i) begin
            r_state         <= ARB_WAIT_RESP;
            r_mem_req_valid <= 1'b0;
          end
        end
        ARB_WAIT_RESP: begin
          if (mem_resp_valid_i) begin
            r_state <= ARB_IDLE;
            if (r_owner == MEM_PORT_D) begin
              r_d_resp_valid <= 1'b1;
              r_d_resp_err   <= 1'b0;
              r_d_rdata      <= r_wr ? '0 : mem_rdata_i;
            end else begin
              r_i_resp_valid <= 1'b1;
              r_i_resp_err   <= 1'b0;
              r_i_rdata      <= mem_rdata_i;
            end
          end
        end
        ARB_ERR_RESP: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign i_req_ready_o   = w_grant_i;
  assign d_req_ready_o   = w_grant_d;
  assign i_resp_valid_o  = r_i_resp_valid;
  assign i_resp_err_o    = r_i_resp_err;
  assign i_rdata_o       = r_i_rdata;
  assign d_resp_valid_o  = r_d_resp_valid;
  assign d_resp_err_o    = r_d_resp_err;
  assign d_rdata_o       = r_d_rdata;
  assign mem_req_valid_o = r_mem_req_valid;
  assign mem_addr_o      = r_addr;
  assign mem_wr_o        = r_wr;
  assign mem_size_o      = r_size;
  assign mem_wdata_o     = r_wdata;
  assign busy_o          = (r_state != ARB_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported tiny5 memory bus between the instruction-fetch requester (I) and the load/store requester (D). The block arbitrates, registers the winning request, holds it on the bus until the memory accepts it, waits for the memory response, and routes that response back to the owner. It sits between the core's fetch/LSU stages and the memory interface. Misaligned accesses are rejected locally and never reach the memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I gets forced priority (>=1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
i_req_valid_i  in  1  fetch request valid
i_req_ready_o  out  1  fetch request accepted this cycle
i_addr_i  in  ADDR_W  fetch address (always a WORD access)
i_resp_valid_o  out  1  fetch response pulse
i_resp_err_o  out  1  fetch misaligned
i_rdata_o  out  DATA_W  fetched word
d_req_valid_i  in  1  data request valid
d_req_ready_o  out  1  data request accepted this cycle
d_addr_i  in  ADDR_W  data address
d_wr_i  in  1  1 = store
d_size_i  in  2  mem_access_size_t
d_wdata_i  in  DATA_W  store data
d_resp_valid_o  out  1  data response pulse (loads and stores)
d_resp_err_o  out  1  data misaligned
d_rdata_o  out  DATA_W  load data; 0 for stores and errors
mem_req_valid_o  out  1  bus request valid
mem_req_ready_i  in  1  bus request accepted
mem_addr_o  out  ADDR_W  bus address
mem_wr_o  out  1  bus write
mem_size_o  out  2  mem_access_size_t
mem_wdata_o  out  DATA_W  bus write data
mem_resp_valid_i  in  1  bus response (read data or write ack)
mem_rdata_i  in  DATA_W  bus read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, streak=0. Every output is 0, including the held request and rdata registers. Any in-flight transaction is dropped; the memory side must also be reset.
- States: IDLE, ISSUE, WAIT_RESP, ERR_RESP.
- IDLE, grant (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, D wins unless streak == MAX_D_STREAK, in which case I wins.
  - The winner's ready_o = 1; the loser's ready_o = 0. Both ready_o are 0 in all other states.
  - On the accepting edge, latch owner, addr, wr, size and wdata. I requests latch wr=0, size=WORD, wdata=0.
  - streak: D grant -> saturating increment to MAX_D_STREAK; I grant -> 0; no grant -> unchanged.
- Misaligned request: WORD with addr[1:0]!=0, or HALF with addr[0]=1. Such a request goes IDLE->ERR_RESP and issues no bus request. In ERR_RESP: owner resp_valid_o=1, err_o=1, rdata_o=0 for one cycle, then IDLE.
- Aligned request: IDLE->ISSUE. In ISSUE, mem_req_valid_o=1 and the mem_* outputs drive the latched fields, held stable until mem_req_ready_i=1. That edge -> WAIT_RESP, mem_req_valid_o=0.
- Memory contract: mem_resp_valid_i is never asserted in the same cycle as the accepting mem_req_ready_i.
- WAIT_RESP: on mem_resp_valid_i, the next cycle asserts owner resp_valid_o=1 for exactly one cycle, err_o=0.
  - rdata_o = mem_rdata_i for loads and fetches; 0 for stores.
  - State returns to IDLE on the same edge, so a new request can be accepted in the pulse cycle.
- Minimum latency with memory ready and responding next cycle: accept t0, bus request t1, mem response t2, resp_valid_o t3. Back-to-back throughput is one transaction per 3 cycles.
- rdata_o/err_o hold their values between pulses. The non-owner's response outputs do not change.
- mem_resp_valid_i outside WAIT_RESP is ignored.
- d_size_i outside {BYTE, HALF, WORD} (value 3) is treated as misaligned.

Decomposition:
- Add to the shared definitions package:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RESP, ARB_ERR_RESP}
  - mem_port_t enum {MEM_PORT_I, MEM_PORT_D}
- Reuse mem_access_size_t for d_size_i and mem_size_o.
- Single module. The alignment check is a local function, not a sub-module.

Test Plan:
- Single fetch: i_addr=0x100, memory returns 0xDEADBEEF one cycle after accept -> mem_addr_o=0x100, size=WORD, wr=0; i_resp_valid_o pulses at t3 with 0xDEADBEEF; d_resp_valid_o stays 0.
- Simultaneous I+D, both valid continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; every transaction receives exactly one response, routed to the correct port.
- Misaligned: D HALF at 0x203, then I WORD at 0x102 -> each gets resp_valid+err=1, rdata=0, and mem_req_valid_o never rises.
- Backpressure: D store addr 0x40, wdata 0x12345678, mem_req_ready_i low for 5 cycles -> mem_* outputs stable for all 6 cycles; d_resp_valid_o after ack with d_rdata_o=0.
- Byte load 0x41 with mem_rdata=0x000000AB -> d_rdata_o=0x000000AB, err=0, size=BYTE on bus.
- reset_n_i low during WAIT_RESP -> all outputs 0 immediately (async); after release, state IDLE, streak 0, a new fetch completes normally.
